// File: rtl/octal_stream_to_binary_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | octal_conv_pkg : shared state encoding and ASCII constants               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package octal_conv_pkg;

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_SEVEN = 8'h37;
  localparam logic [7:0] CH_SEP   = 8'h5F;

endpackage
`default_nettype wire

// File: rtl/octal_stream_to_binary_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | octal_stream_to_binary_if : character input and result output handshakes |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface octal_stream_to_binary_if #(
  parameter int OUT_W = 32,
  parameter int CNT_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_char;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_value;
  logic [CNT_W-1:0] out_ndigits;
  logic             out_err_char;
  logic             out_err_ovf;
  logic             out_err_empty;

  modport master (
    output in_valid, in_char, in_last, out_ready,
    input  in_ready, out_valid, out_value, out_ndigits,
           out_err_char, out_err_ovf, out_err_empty
  );

  modport slave (
    input  in_valid, in_char, in_last, out_ready,
    output in_ready, out_valid, out_value, out_ndigits,
           out_err_char, out_err_ovf, out_err_empty
  );
endinterface
`default_nettype wire

// File: rtl/octal_stream_to_binary_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | octal_ascii_decode : classifies one ASCII character as octal digit/sep   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module octal_ascii_decode
  import octal_conv_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_digit_o,
  output logic       is_sep_o,
  output logic [2:0] digit_o
);
  assign is_digit_o = (char_i >= CH_ZERO) && (char_i <= CH_SEVEN);
  assign is_sep_o   = (char_i == CH_SEP);
  assign digit_o    = char_i[2:0];
endmodule
`default_nettype wire

// File: rtl/octal_stream_to_binary.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | octal_stream_to_binary : ASCII-octal frame to OUT_W-bit binary word      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module octal_stream_to_binary
  import octal_conv_pkg::*;
#(
  parameter int OUT_W = 32,
  parameter int CNT_W = 6
) (
  input logic                      clk,
  input logic                      rst_n,
  octal_stream_to_binary_if.slave  bus
);
  localparam logic [0:0]       S_ACC   = ST_ACC;
  localparam logic [0:0]       S_HOLD  = ST_HOLD;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]       state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_char_q, err_char_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_empty_q, err_empty_d;

  logic             w_is_digit;
  logic             w_is_sep;
  logic [2:0]       w_digit;
  logic [OUT_W-1:0] w_acc_shift;

  octal_ascii_decode u_decode (
    .char_i     (bus.in_char),
    .is_digit_o (w_is_digit),
    .is_sep_o   (w_is_sep),
    .digit_o    (w_digit)
  );

  generate
    if (OUT_W > 3) begin : g_wide
      assign w_acc_shift = {acc_q[OUT_W-4:0], w_digit};
    end else begin : g_narrow
      assign w_acc_shift = w_digit;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_char_d  = err_char_q;
    err_ovf_d   = err_ovf_q;
    err_empty_d = err_empty_q;
    case (state_q)
      S_ACC: begin
        if (bus.in_valid) begin
          if (w_is_digit) begin
            acc_d     = w_acc_shift;
            err_ovf_d = err_ovf_q | (|acc_q[OUT_W-1:OUT_W-3]);
            cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          end else if (!w_is_sep) begin
            err_char_d = 1'b1;
          end
          if (bus.in_last) begin
            state_d     = S_HOLD;
            err_empty_d = (cnt_d == '0);
          end
        end
      end
      S_HOLD: begin
        // Acceptance clears the whole frame context so the next frame starts clean.
        if (bus.out_ready) begin
          state_d     = S_ACC;
          acc_d       = '0;
          cnt_d       = '0;
          err_char_d  = 1'b0;
          err_ovf_d   = 1'b0;
          err_empty_d = 1'b0;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_char_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_empty_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_char_q  <= err_char_d;
      err_ovf_q   <= err_ovf_d;
      err_empty_q <= err_empty_d;
    end
  end

  assign bus.in_ready      = (state_q == S_ACC);
  assign bus.out_valid     = (state_q == S_HOLD);
  assign bus.out_value     = acc_q;
  assign bus.out_ndigits   = cnt_q;
  assign bus.out_err_char  = err_char_q;
  assign bus.out_err_ovf   = err_ovf_q;
  assign bus.out_err_empty = err_empty_q;
endmodule
`default_nettype wire

// File: tb/tb_octal_stream_to_binary.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_octal_stream_to_binary : drives 32-bit and 8-bit converters in step   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_octal_stream_to_binary;
  typedef byte bq_t[$];

  logic       clk;
  logic       rst_n;
  logic       tb_in_valid;
  logic [7:0] tb_in_char;
  logic       tb_in_last;
  logic       tb_out_ready;
  int         checks;
  int         errors;

  octal_stream_to_binary_if #(.OUT_W(32), .CNT_W(6)) ifw ();
  octal_stream_to_binary_if #(.OUT_W(8),  .CNT_W(6)) ifn ();

  assign ifw.in_valid  = tb_in_valid;
  assign ifw.in_char   = tb_in_char;
  assign ifw.in_last   = tb_in_last;
  assign ifw.out_ready = tb_out_ready;
  assign ifn.in_valid  = tb_in_valid;
  assign ifn.in_char   = tb_in_char;
  assign ifn.in_last   = tb_in_last;
  assign ifn.out_ready = tb_out_ready;

  octal_stream_to_binary #(.OUT_W(32), .CNT_W(6)) u_dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifw)
  );

  octal_stream_to_binary #(.OUT_W(8), .CNT_W(6)) u_dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret the frame as an unbounded octal number, then truncate.
  task automatic model(input bq_t q, input int w, output logic [63:0] val,
                       output int nd, output bit ec, output bit ov, output bit em);
    logic [255:0] a;
    logic [7:0]   c;
    a  = '0;
    nd = 0;
    ec = 1'b0;
    foreach (q[i]) begin
      c = q[i];
      if (c >= 8'h30 && c <= 8'h37) begin
        a = a * 8 + 256'(c - 8'h30);
        if (nd < 63) nd++;
      end else if (c != 8'h5F) begin
        ec = 1'b1;
      end
    end
    val = 64'(a & ((256'd1 << w) - 1));
    ov  = (a >> w) != 0;
    em  = (nd == 0);
  endtask

  task automatic check_out(input string tag, input bq_t q);
    logic [63:0] v;
    int          nd;
    bit          ec, ov, em;
    model(q, 32, v, nd, ec, ov, em);
    chk({tag, " w32 out_valid"}, 64'(ifw.out_valid), 64'd1);
    chk({tag, " w32 in_ready"},  64'(ifw.in_ready), 64'd0);
    chk({tag, " w32 value"},     64'(ifw.out_value), v);
    chk({tag, " w32 ndigits"},   64'(ifw.out_ndigits), 64'(nd));
    chk({tag, " w32 err_char"},  64'(ifw.out_err_char), 64'(ec));
    chk({tag, " w32 err_ovf"},   64'(ifw.out_err_ovf), 64'(ov));
    chk({tag, " w32 err_empty"}, 64'(ifw.out_err_empty), 64'(em));
    model(q, 8, v, nd, ec, ov, em);
    chk({tag, " w8 out_valid"},  64'(ifn.out_valid), 64'd1);
    chk({tag, " w8 value"},      64'(ifn.out_value), v);
    chk({tag, " w8 ndigits"},    64'(ifn.out_ndigits), 64'(nd));
    chk({tag, " w8 err_char"},   64'(ifn.out_err_char), 64'(ec));
    chk({tag, " w8 err_ovf"},    64'(ifn.out_err_ovf), 64'(ov));
    chk({tag, " w8 err_empty"},  64'(ifn.out_err_empty), 64'(em));
  endtask

  // Entered and left at a falling edge.
  task automatic send(input bq_t q, input bit gaps, input bit close);
    foreach (q[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        tb_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
      end
      chk("in_ready during frame", 64'(ifw.in_ready & ifn.in_ready), 64'd1);
      chk("out_valid during frame", 64'(ifw.out_valid | ifn.out_valid), 64'd0);
      tb_in_valid = 1'b1;
      tb_in_char  = q[i];
      tb_in_last  = close && (i == q.size() - 1);
      @(posedge clk);
      @(negedge clk);
    end
    tb_in_valid = 1'b0;
    tb_in_last  = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bq_t q, input bit gaps, input int stall);
    send(q, gaps, 1'b1);
    check_out(tag, q);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_out({tag, " stalled"}, q);
    end
    tb_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_out_ready = 1'b0;
    chk({tag, " after accept out_valid"}, 64'(ifw.out_valid | ifn.out_valid), 64'd0);
    chk({tag, " after accept in_ready"},  64'(ifw.in_ready & ifn.in_ready), 64'd1);
    chk({tag, " after accept value"},     64'(ifw.out_value), 64'd0);
    chk({tag, " after accept ndigits"},   64'(ifw.out_ndigits), 64'd0);
    chk({tag, " after accept flags"},
        64'({ifw.out_err_char, ifw.out_err_ovf, ifw.out_err_empty}), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " in_ready"},  64'(ifw.in_ready & ifn.in_ready), 64'd1);
    chk({tag, " out_valid"}, 64'(ifw.out_valid | ifn.out_valid), 64'd0);
    chk({tag, " value"},     64'(ifw.out_value) | 64'(ifn.out_value), 64'd0);
    chk({tag, " ndigits"},   64'(ifw.out_ndigits) | 64'(ifn.out_ndigits), 64'd0);
    chk({tag, " flags"},     64'({ifw.out_err_char, ifw.out_err_ovf, ifw.out_err_empty,
                                  ifn.out_err_char, ifn.out_err_ovf, ifn.out_err_empty}), 64'd0);
  endtask

  initial begin
    bq_t q;
    int  len;
    int  r;
    byte c;
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    tb_in_valid  = 1'b0;
    tb_in_char   = 8'h00;
    tb_in_last   = 1'b0;
    tb_out_ready = 1'b0;

    #12;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame("t1 017", s2q("017"), 1'b0, 0);
    run_frame("t2 7_7", s2q("7_7"), 1'b0, 0);
    run_frame("t3 777", s2q("777"), 1'b0, 0);
    run_frame("t3 377", s2q("377"), 1'b0, 0);
    run_frame("t4 19",  s2q("19"),  1'b0, 0);
    run_frame("t4 sep", s2q("_"),   1'b0, 0);
    run_frame("t5 stall", s2q("4021"), 1'b0, 5);
    run_frame("t5 next", s2q("5"), 1'b0, 0);

    // Asynchronous reset in the middle of a frame, between clock edges.
    send(s2q("12"), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_idle("async reset mid-frame");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("t6 3", s2q("3"), 1'b0, 0);

    q = {};
    for (int i = 0; i < 10; i++) q = {q, s2q("1234567")};
    run_frame("saturate 70 digits", q, 1'b0, 1);

    for (int f = 0; f < 25; f++) begin
      q   = {};
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 99);
        if (r < 80) begin
          c = byte'(8'h30 + $urandom_range(0, 7));
        end else if (r < 90) begin
          c = byte'(8'h5F);
        end else begin
          c = byte'($urandom_range(0, 255));
          if ((c >= 8'sh30 && c <= 8'sh37) || c == 8'sh5F) c = byte'(8'h39);
        end
        q.push_back(c);
      end
      run_frame($sformatf("random frame %0d", f), q, 1'b1, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
